sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
Upstream neighbour of the sobel stage. Accepts a raster-order stream of 8-bit greyscale pixels, one per handshake. Buffers the two previous image rows and emits one 3x3 neighbourhood per interior pixel with its centre coordinates, for the Sobel gradient/threshold stage to consume. Replaces the flat whole-image bus with a streaming interface.

Parameters:
WIDTH, 128, image width in pixels (>=3)
DEPTH, 128, image height in rows (>=3)
PIX_W, 8, bits per pixel

Ports:
ClkPort  input  1  system clock, all logic on rising edge
ResetN  input  1  asynchronous active-low reset
in_valid  input  1  in_pixel valid
in_ready  output  1  block can accept a pixel this cycle
in_pixel  input  PIX_W  pixel, raster order (x fastest, then y)
out_valid  output  1  out_window/out_x/out_y/out_last valid
out_ready  input  1  downstream accepts the window
out_window  output  9*PIX_W  3x3 window; slot (r,c) at bits [PIX_W*(3*r+c) +: PIX_W], r=0 top row, c=0 left column
out_x  output  $clog2(WIDTH)  centre column, 1..WIDTH-2
out_y  output  $clog2(DEPTH)  centre row, 1..DEPTH-2
out_last  output  1  final window of the frame (centre WIDTH-2, DEPTH-2)

Behaviour:
- Reset (async, ResetN=0):
  - col/row counters = 0
  - out_valid = 0, out_last = 0, out_x = 0, out_y = 0
  - window registers = 0
  - line-buffer RAM not reset; contents are don't-care
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- On accept of pixel P at (x,y):
  - Read lb1[x] (row y-1) and lb2[x] (row y-2).
  - Write lb2[x] <= lb1[x] and lb1[x] <= P.
  - Shift the window columns left: c0<=c1, c1<=c2. New c2 = {lb2[x], lb1[x], P} for rows r=0,1,2.
- Output: after accept at (x,y) with x>=2 and y>=2, next cycle:
  - out_valid=1
  - out_x=x-1, out_y=y-1
  - slot (r,c) = pixel(x-2+c, y-2+r)
  - Latency 1 cycle accept-to-valid.
- Non-emitting accepts (x<2 or y<2):
  - if out_ready is high that cycle, out_valid falls to 0
  - otherwise out_valid and the window stay held
- out_valid stays high with all outputs stable until out_ready=1. Window registers shift only on accept, and accept cannot occur while out_valid && !out_ready.
- Counters:
  - x increments per accept.
  - At x=WIDTH-1: x wraps to 0 and y increments.
  - At x=WIDTH-1, y=DEPTH-1: both wrap to 0 and the next pixel begins a new frame with no gap cycle.
- out_last=1 exactly on the window centred (WIDTH-2, DEPTH-2); 0 on all others.
- Throughput: one window per cycle in steady state with continuous in_valid/out_ready. Exactly (WIDTH-2)*(DEPTH-2) windows per frame.
- Stale data in window columns at row start is never emitted, because x<2 suppresses output.
- Reset mid-frame: pending window dropped, counters return to 0, next accepted pixel is (0,0).
- Simultaneous out_ready=1 and accept: the old window is consumed and the new window or valid state is loaded in the same edge, with no bubble.

Optional Feature:
FRAME_CNT_EN
- Defined:
  - adds output frame_count, 16 bits, reset 0
  - increments on the handshake (out_valid && out_ready) of the out_last window
  - wraps 0xFFFF to 0
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- WIDTH=4, DEPTH=4, pixel=16*y+x, out_ready=1, in_valid=1 continuous -> exactly 4 windows:
  - first: centre (1,1), slots {0,1,2,16,17,18,32,33,34}
  - last: centre (2,2), slots {17,18,19,33,34,35,49,50,51}, out_last=1 only there
- Same frame, out_ready held 0 for 5 cycles after first out_valid -> in_ready=0 for those 5 cycles, window (1,1) held unchanged, then the stream resumes with no lost or duplicated windows.
- Random in_valid gaps (~50%) with a 128x128 frame -> 126*126=15876 windows. Each window matches a reference-model 3x3 of the image; out_x/out_y sweep 1..126 in raster order.
- Two back-to-back 4x4 frames, second pixel=100+16*y+x -> 8 windows. Window 5 centre (1,1) = {100,101,102,116,117,118,132,133,134}; out_last on windows 4 and 8.
- ResetN pulsed low mid-row 2 of a 4x4 frame, then a full frame sent -> out_valid=0 immediately (async). Exactly 4 correct windows follow, with no stale window.
- FRAME_CNT_EN defined, 3 frames of 4x4 -> frame_count steps 0->1->2->3, each step on the out_last handshake; after reset, reads 0.

Source files
------------

// File: rtl/sobel_window_gen.sv
// Streams raster-order pixels through two line buffers and emits every interior 3x3 window.
// Optional macro FRAME_CNT_EN adds a 16-bit frame_count output.
module sobel_window_gen #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 128,
    parameter int PIX_W = 8,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(DEPTH)
) (
    input  logic               ClkPort,
    input  logic               ResetN,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [9*PIX_W-1:0] out_window,
    output logic [XW-1:0]      out_x,
    output logic [YW-1:0]      out_y,
    output logic               out_last
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0]        frame_count
`endif
);

    logic [XW-1:0]    col;
    logic [YW-1:0]    row;
    logic [PIX_W-1:0] lb1 [WIDTH];
    logic [PIX_W-1:0] lb2 [WIDTH];
    logic [PIX_W-1:0] win [3][3];
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] lb2_rd;
    logic             accept;
    logic             emit;
    logic             col_end;
    logic             row_end;

    // valid/ready: a transfer happens on a rising edge where valid && ready; a held
    // out_valid keeps all out_* stable, and the input side stalls only while a window waits.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_end  = (col == XW'(WIDTH - 1));
    assign row_end  = (row == YW'(DEPTH - 1));
    assign emit     = (col >= XW'(2)) && (row >= YW'(2));
    assign lb1_rd   = lb1[col];
    assign lb2_rd   = lb2[col];

    always_ff @(posedge ClkPort) begin
        if (accept) begin
            lb2[col] <= lb1_rd;
            lb1[col] <= in_pixel;
        end
    end

    always_ff @(posedge ClkPort or negedge ResetN) begin
        if (!ResetN) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + YW'(1);
            end else begin
                col <= col + XW'(1);
            end
        end
    end

    always_ff @(posedge ClkPort or negedge ResetN) begin
        if (!ResetN) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= in_pixel;
        end
    end

    // The window column at x<2 still holds the previous row's tail, hence the emit gate.
    always_ff @(posedge ClkPort or negedge ResetN) begin
        if (!ResetN) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else if (accept) begin
            out_valid <= emit;
            out_last  <= emit && col_end && row_end;
            if (emit) begin
                out_x <= col - XW'(1);
                out_y <= row - YW'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    always_comb begin
        out_window = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                out_window[PIX_W*(3*r+c) +: PIX_W] = win[r][c];
            end
        end
    end

`ifdef FRAME_CNT_EN
    always_ff @(posedge ClkPort or negedge ResetN) begin
        if (!ResetN) begin
            frame_count <= '0;
        end else if (out_valid && out_ready && out_last) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: a 4x4 instance for directed cases and a 128x128 instance
// for a randomized frame, both checked against an image-level 3x3 reference model.
module tb_sobel_window_gen;

    localparam int EW = 87; // {last, y[6:0], x[6:0], window[71:0]}

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  in_pixel;

    logic        s_in_ready, s_out_valid, s_out_last;
    logic [71:0] s_win;
    logic [1:0]  s_x, s_y;
    logic        l_in_ready, l_out_valid, l_out_last;
    logic [71:0] l_win;
    logic [6:0]  l_x, l_y;

    logic        in_ready, out_valid, mlast;
    logic [71:0] mwin;
    logic [6:0]  mx, my;
`ifdef FRAME_CNT_EN
    logic [15:0] s_fc, l_fc, mfc;
    int          fc_model [2];
`endif

    logic [7:0]    img [128][128];
    logic [7:0]    pix_q [$];
    logic [EW-1:0] exp_q [$];
    int            n_cmp;
    int            n_fail;
    int            n_win;

    sobel_window_gen #(.WIDTH(4), .DEPTH(4), .PIX_W(8)) dut_s (
        .ClkPort    (clk),
        .ResetN     (rst_n),
        .in_valid   (in_valid && !sel),
        .in_ready   (s_in_ready),
        .in_pixel   (in_pixel),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready || sel),
        .out_window (s_win),
        .out_x      (s_x),
        .out_y      (s_y),
        .out_last   (s_out_last)
`ifdef FRAME_CNT_EN
        ,
        .frame_count(s_fc)
`endif
    );

    sobel_window_gen #(.WIDTH(128), .DEPTH(128), .PIX_W(8)) dut_l (
        .ClkPort    (clk),
        .ResetN     (rst_n),
        .in_valid   (in_valid && sel),
        .in_ready   (l_in_ready),
        .in_pixel   (in_pixel),
        .out_valid  (l_out_valid),
        .out_ready  (out_ready || !sel),
        .out_window (l_win),
        .out_x      (l_x),
        .out_y      (l_y),
        .out_last   (l_out_last)
`ifdef FRAME_CNT_EN
        ,
        .frame_count(l_fc)
`endif
    );

    always_comb begin
        in_ready  = sel ? l_in_ready  : s_in_ready;
        out_valid = sel ? l_out_valid : s_out_valid;
        mlast     = sel ? l_out_last  : s_out_last;
        mwin      = sel ? l_win       : s_win;
        mx        = sel ? l_x         : {5'b0, s_x};
        my        = sel ? l_y         : {5'b0, s_y};
`ifdef FRAME_CNT_EN
        mfc       = sel ? l_fc        : s_fc;
`endif
    end

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
`ifdef FRAME_CNT_EN
        fc_model[0] = 0;
        fc_model[1] = 0;
`endif
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: whole image in an array, windows enumerated by centre in raster order
    task automatic build_frame(input int w, input int d, input bit rnd, input int base);
        logic [7:0]  p;
        logic [71:0] wv;
        for (int y = 0; y < d; y++) begin
            for (int x = 0; x < w; x++) begin
                p = rnd ? 8'($urandom) : 8'(base + 16*y + x);
                img[y][x] = p;
                pix_q.push_back(p);
            end
        end
        for (int cy = 1; cy <= d-2; cy++) begin
            for (int cx = 1; cx <= w-2; cx++) begin
                wv = '0;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        wv[8*(3*r+c) +: 8] = img[cy-1+r][cx-1+c];
                    end
                end
                exp_q.push_back({(cx == w-2 && cy == d-2), 7'(cy), 7'(cx), wv});
            end
        end
    endtask

    // driver: mode 0 ready=1, 1 random ready, 2 one 5-cycle stall at first valid, 3 ready=0
    task automatic run_stream(input int gap, input int mode, input int acc_limit, input int budget);
        int  cyc = 0;
        int  acc = 0;
        int  stall_left = 0;
        bit  stall_done = 0;
        bit  stalled;
        bit  took;
        bit  done = 0;
        while (!done && cyc < budget) begin
            in_valid = (pix_q.size() != 0) && (acc < acc_limit) && ($urandom_range(0, 99) >= gap);
            in_pixel = (pix_q.size() != 0) ? pix_q[0] : 8'h00;
            if (mode == 2 && !stall_done && out_valid) begin
                stall_left = 5;
                stall_done = 1;
            end
            stalled = 0;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 99) < 80);
                2: begin
                    stalled = (stall_left > 0);
                    out_ready = !stalled;
                end
                default: out_ready = 1'b0;
            endcase
            @(negedge clk);
            if (stalled) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_window_held", mwin, exp_q[0][71:0]);
                stall_left--;
            end
            took = in_valid && in_ready;
            @(posedge clk);
            if (took) begin
                void'(pix_q.pop_front());
                acc++;
            end
            #1;
            cyc++;
            done = (mode == 3) ? (acc >= acc_limit) : (pix_q.size() == 0 && exp_q.size() == 0);
        end
        check("stream_timeout", done, 1);
        in_valid = 1'b0;
        if (mode != 3) begin
            out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    // scoreboard: every output handshake pops and compares one expected window
    always @(negedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        if (rst_n && out_valid && out_ready) begin
            n_win++;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL extra_window: observed x=%0d y=%0d expected no window", mx, my);
            end
            if (exp_q.size() != 0) begin
                got = {mlast, my, mx, mwin};
                e = exp_q.pop_front();
                n_cmp++;
                assert (got === e) else begin
                    n_fail++;
                    $error("FAIL window: observed %h expected %h", got, e);
                end
`ifdef FRAME_CNT_EN
                n_cmp++;
                assert (mfc === 16'(fc_model[sel])) else begin
                    n_fail++;
                    $error("FAIL frame_count: observed %0d expected %0d", mfc, fc_model[sel]);
                end
                if (e[EW-1]) fc_model[sel]++;
`endif
            end
        end
    end

    initial begin
        int w0;
        n_cmp = 0;
        n_fail = 0;
        n_win = 0;
        sel = 1'b0;
        in_valid = 1'b0;
        in_pixel = 8'h00;
        out_ready = 1'b1;
        apply_reset();

        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", mlast, 0);
        check("rst_out_x", mx, 0);
        check("rst_out_y", my, 0);
        check("rst_window", mwin, 0);
        check("rst_in_ready", in_ready, 1);

        // single 4x4 frame, continuous flow
        build_frame(4, 4, 0, 0);
        w0 = n_win;
        run_stream(0, 0, 1 << 30, 200);
        check("frame1_count", n_win - w0, 4);

        // same frame with a 5-cycle downstream stall on the first window
        build_frame(4, 4, 0, 0);
        w0 = n_win;
        run_stream(0, 2, 1 << 30, 200);
        check("stall_count", n_win - w0, 4);

        // two back-to-back frames, no gap
        build_frame(4, 4, 0, 0);
        build_frame(4, 4, 0, 100);
        w0 = n_win;
        run_stream(0, 0, 1 << 30, 200);
        check("b2b_count", n_win - w0, 8);

        // reset in row 2 with the (1,1) window pending
        build_frame(4, 4, 0, 0);
        run_stream(0, 3, 11, 200);
        check("pre_reset_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_x", mx, 0);
        pix_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
`ifdef FRAME_CNT_EN
        fc_model[0] = 0;
        fc_model[1] = 0;
        check("fc_after_reset", mfc, 0);
`endif
        build_frame(4, 4, 0, 0);
        w0 = n_win;
        run_stream(0, 0, 1 << 30, 200);
        check("post_reset_count", n_win - w0, 4);

        // full-size randomized frame with input gaps and downstream backpressure
        sel = 1'b1;
        build_frame(128, 128, 1, 0);
        w0 = n_win;
        run_stream(50, 1, 1 << 30, 80000);
        check("large_count", n_win - w0, 15876);
        check("large_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
